// File: rtl/alu_8bit_seq_if.sv
// Request/response bundle for the sequential 8-bit ALU: operands and opcode in,
// registered result and flags out, each direction with its own valid/ready pair.
interface alu_8bit_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero
    );
endinterface

// File: rtl/alu_8bit_seq.sv
// Sequential 8-bit ALU: logic/add/sub/shift in 1 cycle, shift-add MUL in 9 edges.
// One op in flight; in_ready drops until the result is taken, and results hold while out_ready is low.
module and_8bit (
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] z
);
    assign z = x & y;
endmodule

module alu_8bit_seq (
    input  logic         clk,
    input  logic         rst,
    alu_8bit_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    state_t      state;
    state_t      state_nx;
    logic        accept;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] product;
    logic [2:0]  iter;
    logic [7:0]  res_q;
    logic        carry_q;
    logic        zero_q;

    logic [7:0]  and_res;
    logic [8:0]  sum9;
    logic [7:0]  alu_res;
    logic        alu_c;
    logic [15:0] partial;
    logic [15:0] prod_nx;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign accept        = bus.in_valid && bus.in_ready;

    and_8bit u_and (
        .x(bus.a),
        .y(bus.b),
        .z(and_res)
    );

    assign sum9 = {1'b0, bus.a} + {1'b0, bus.b};

    // Single-cycle ops work straight off the request inputs so the result lands on the accept edge.
    always_comb begin
        alu_res = 8'h00;
        alu_c   = 1'b0;
        case (bus.op)
            OP_AND: alu_res = and_res;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_ADD: begin
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
            end
            OP_SUB: begin
                alu_res = bus.a - bus.b;
                alu_c   = (bus.a < bus.b);
            end
            OP_SHL: begin
                alu_res = {bus.a[6:0], 1'b0};
                alu_c   = bus.a[7];
            end
            OP_SHR: begin
                alu_res = {1'b0, bus.a[7:1]};
                alu_c   = bus.a[0];
            end
            default: begin
                alu_res = 8'h00;
                alu_c   = 1'b0;
            end
        endcase
    end

    assign partial = b_q[iter] ? ({8'h00, a_q} << iter) : 16'h0000;
    assign prod_nx = product + partial;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (bus.op == OP_MUL) ? EXEC : DONE;
            EXEC: if (iter == 3'd7) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            product <= 16'h0000;
            iter    <= 3'd0;
            res_q   <= 8'h00;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.op == OP_MUL) begin
                            a_q     <= bus.a;
                            b_q     <= bus.b;
                            product <= 16'h0000;
                            iter    <= 3'd0;
                        end else begin
                            res_q   <= alu_res;
                            carry_q <= alu_c;
                            zero_q  <= (alu_res == 8'h00);
                        end
                    end
                end
                EXEC: begin
                    product <= prod_nx;
                    iter    <= iter + 3'd1;
                    // Publish only on the last partial product so outputs never show a half-built value.
                    if (iter == 3'd7) begin
                        res_q   <= prod_nx[7:0];
                        carry_q <= |prod_nx[15:8];
                        zero_q  <= (prod_nx[7:0] == 8'h00);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_8bit_seq.sv
// Directed bench for alu_8bit_seq: reset, every opcode, MUL latency, backpressure, reset mid-MUL.
module tb_alu_8bit_seq;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_8bit_seq_if bus();

    alu_8bit_seq dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one request, scramble inputs after acceptance, measure accept-to-valid edges,
    // optionally stall the consumer for 'hold' cycles with spurious requests, then hand-shake.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input int lat, input logic [7:0] er,
                          input logic ec, input logic ez, input int hold);
        int edges;
        chk({tag, ".in_ready"}, bus.in_ready, 1);
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = ~x;
        bus.b        = ~y;
        bus.op       = o ^ 3'b001;
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, edges, lat);
        chk({tag, ".result"}, bus.result, er);
        chk({tag, ".carry"}, bus.carry, ec);
        chk({tag, ".zero"}, bus.zero, ez);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = 3'b011;
            bus.a        = 8'h11;
            bus.b        = 8'h22;
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold.out_valid"}, bus.out_valid, 1);
            chk({tag, ".hold.in_ready"}, bus.in_ready, 0);
            chk({tag, ".hold.result"}, bus.result, er);
            chk({tag, ".hold.carry"}, bus.carry, ec);
            chk({tag, ".hold.zero"}, bus.zero, ez);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".post.out_valid"}, bus.out_valid, 0);
        chk({tag, ".post.in_ready"}, bus.in_ready, 1);
        chk({tag, ".post.result"}, bus.result, er);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen_valid;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 3'b011;
        bus.a         = 8'hFF;
        bus.b         = 8'h01;
        bus.out_ready = 1'b0;

        // Reset held two edges with a request pending.
        @(negedge clk);
        chk("rst.in_ready_during", bus.in_ready, 0);
        @(negedge clk);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.result", bus.result, 8'h00);
        chk("rst.carry", bus.carry, 0);
        chk("rst.zero", bus.zero, 0);
        chk("rst.in_ready_held", bus.in_ready, 0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst.in_ready_after", bus.in_ready, 1);
        chk("rst.no_accept", bus.out_valid, 0);

        // out_ready while idle must not do anything.
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle.out_ready.out_valid", bus.out_valid, 0);
        chk("idle.out_ready.in_ready", bus.in_ready, 1);

        run_op("and",   3'b000, 8'hAA, 8'hCC, 1, 8'h88, 1'b0, 1'b0, 0);
        run_op("add",   3'b011, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1, 0);
        run_op("or",    3'b001, 8'h0F, 8'hF0, 1, 8'hFF, 1'b0, 1'b0, 0);
        run_op("xor",   3'b010, 8'h5A, 8'h5A, 1, 8'h00, 1'b0, 1'b1, 0);
        run_op("sub_b", 3'b100, 8'h03, 8'h05, 1, 8'hFE, 1'b1, 1'b0, 0);
        run_op("sub",   3'b100, 8'h05, 8'h03, 1, 8'h02, 1'b0, 1'b0, 0);
        run_op("shl",   3'b110, 8'h81, 8'hFF, 1, 8'h02, 1'b1, 1'b0, 0);
        run_op("mul1",  3'b101, 8'h10, 8'h11, 9, 8'h10, 1'b1, 1'b0, 0);
        run_op("mul2",  3'b101, 8'h0F, 8'h0F, 9, 8'hE1, 1'b0, 1'b0, 0);
        run_op("mul0",  3'b101, 8'h00, 8'hFF, 9, 8'h00, 1'b0, 1'b1, 2);
        run_op("bp",    3'b011, 8'h7F, 8'h01, 1, 8'h80, 1'b0, 1'b0, 5);
        run_op("shr",   3'b111, 8'h01, 8'h00, 1, 8'h00, 1'b1, 1'b1, 0);

        // Reset landing in the 4th EXEC cycle of a multiply.
        bus.op       = 3'b101;
        bus.a        = 8'h0F;
        bus.b        = 8'h0F;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mid.busy.out_valid", bus.out_valid, 0);
            chk("mid.busy.in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid.rst.out_valid", bus.out_valid, 0);
        chk("mid.rst.result", bus.result, 8'h00);
        chk("mid.rst.carry", bus.carry, 0);
        chk("mid.rst.zero", bus.zero, 0);
        rst = 1'b0;
        #1;
        chk("mid.rst.in_ready", bus.in_ready, 1);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            seen_valid = seen_valid | bus.out_valid;
        end
        chk("mid.never_valid", seen_valid, 0);
        run_op("mul3", 3'b101, 8'h03, 8'h05, 9, 8'h0F, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_8bit_seq.md
ALU_8BIT_SEQ -- requirements
Module: alu_8bit_seq

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand/opcode request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110 SHL, 111 SHR.
REQ-007 a  input  8  operand A.
REQ-008 b  input  8  operand B.
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  8  registered result.
REQ-012 carry  output  1  registered carry/borrow/overflow flag.
REQ-013 zero  output  1  registered zero flag.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, EXEC, DONE.
REQ-015 in_ready SHALL equal (state==IDLE && !rst); out_valid SHALL equal (state==DONE).
REQ-016 A request SHALL be accepted on a rising edge where in_valid && in_ready; a, b, op are captured on that edge, later input changes are ignored.
REQ-017 For op != 101 the result SHALL be computed and registered on the accepting edge, state IDLE -> DONE; out_valid high in the next cycle (latency 1).
REQ-018 AND SHALL be computed through an instance of and_8bit; OR/XOR bitwise.
REQ-019 ADD: result=(a+b)[7:0], carry=bit 8 of 9-bit sum.
REQ-020 SUB: result=(a-b)[7:0] modulo 256, carry=1 iff a<b (borrow).
REQ-021 SHL: result={a[6:0],0}, carry=a[7]; SHR: result={0,a[7:1]}, carry=a[0]; b ignored.
REQ-022 AND/OR/XOR: carry=0.
REQ-023 MUL SHALL be shift-add, one bit of b per cycle: accepting edge -> EXEC with 16-bit product=0, iteration counter=0; 8 EXEC edges; 8th EXEC edge -> DONE; out_valid high 8 cycles after acceptance cycle's following cycle (9 edges from accept to out_valid high, inclusive).
REQ-024 MUL: result=product[7:0], carry=1 iff product[15:8]!=0.
REQ-025 zero SHALL be 1 iff registered result==8'h00, for all ops.
REQ-026 In DONE, result/carry/zero SHALL be held stable until the edge where out_ready=1; that edge moves DONE -> IDLE.
REQ-027 No bypass: in_ready=0 during EXEC and DONE; a new request is accepted no earlier than the cycle after the output handshake (max throughput: one single-cycle op per 2 cycles).
REQ-028 out_ready while not in DONE SHALL have no effect; in_valid outside IDLE SHALL have no effect.
REQ-029 Registered outputs SHALL change only on the accepting edge (non-MUL) or the final EXEC edge (MUL), never during DONE.

Reset
REQ-030 On any edge with rst=1: state=IDLE, result=8'h00, carry=0, zero=0, iteration counter=0, product=0.
REQ-031 rst SHALL take priority over all handshakes; an in-flight MUL or un-consumed DONE result is discarded and not reported.
REQ-032 A request presented while rst=1 SHALL NOT be accepted; in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-033 Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, result=00, carry=0, zero=0, no acceptance; in_ready=1 after release.
REQ-034 AND/ADD: op=000 a=AA b=CC -> 1 cycle later out_valid=1 result=88 carry=0 zero=0; op=011 a=FF b=01 -> result=00 carry=1 zero=1.
REQ-035 SUB/shift: op=100 a=03 b=05 -> result=FE carry=1; op=110 a=81 -> result=02 carry=1; op=111 a=01 -> result=00 carry=1 zero=1.
REQ-036 MUL: op=101 a=10 b=11 -> out_valid rises 9 edges after accept, result=10 carry=1 zero=0; a=0F b=0F -> result=E1 carry=0.
REQ-037 Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-038 Reset mid-MUL: assert rst on 4th EXEC cycle -> IDLE, out_valid never asserts for that op, outputs cleared.
